// File: rtl/fixed2float_pkg.sv
// Shared constants, payload types and helpers for the fp16 <-> Q18.25 fixed-point converters.
package fixed2float_pkg;

  localparam int unsigned FIX_W      = 44;
  localparam int unsigned FRAC_W     = 25;
  localparam int unsigned FP_EXP_W   = 5;
  localparam int unsigned FP_MAN_W   = 10;
  localparam int unsigned FP_BIAS    = 15;
  localparam int unsigned FP_W       = 1 + FP_EXP_W + FP_MAN_W;
  localparam logic [14:0] FP_SAT_MAG = 15'h7FFF;

  localparam int unsigned POS_W      = 6;
  localparam int unsigned EXP_FULL_W = 7;
  localparam int unsigned FP_EXP_MAX = (1 << FP_EXP_W) - 1;
  // Leading-one position p maps to exponent p - EXP_OFS (LSB weight 2^-FRAC_W, bias FP_BIAS)
  localparam int unsigned EXP_OFS    = FRAC_W - FP_BIAS;

  // Bit positions inside the magnitude once its leading one sits at the MSB
  localparam int unsigned NORM_MAN_HI = FIX_W - 2;
  localparam int unsigned NORM_MAN_LO = FIX_W - 1 - FP_MAN_W;
  localparam int unsigned NORM_GRD    = NORM_MAN_LO - 1;

  typedef struct packed {
    logic                 sign;
    logic [FP_EXP_W-1:0]  exp;
    logic [FP_MAN_W-1:0]  man;
  } fp16_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [FIX_W-1:0]  mag;
  } s1_t;

  typedef struct packed {
    logic              sign;
    logic              zero;
    logic [POS_W-1:0]  pos;
    logic [FIX_W-1:0]  mag;
  } s2_t;

  // Unsigned magnitude of a two's-complement word; the most negative value maps to 2^(FIX_W-1)
  function automatic logic [FIX_W-1:0] fix_mag(input logic [FIX_W-1:0] x);
    return x[FIX_W-1] ? ((~x) + FIX_W'(1)) : x;
  endfunction

endpackage

// File: rtl/fixed2float_lzd44.sv
// Combinational 44-bit leading-one detector: position of the highest set bit plus an all-zero flag.
module lzd44
  import fixed2float_pkg::*;
(
  input  logic [FIX_W-1:0] vec,
  output logic [POS_W-1:0] pos_c,
  output logic             zero_c
);

  // Ascending scan so the highest set bit wins
  always_comb begin
    pos_c = '0;
    for (int i = 0; i < int'(FIX_W); i++) begin
      if (vec[i]) pos_c = POS_W'(i);
    end
  end

  assign zero_c = ~|vec;

endmodule

// File: rtl/fixed2float.sv
// Q18.25 fixed-point to fp16 converter: 3-stage pipeline (magnitude, leading-one, round/pack)
// under a single global stall with valid/ready handshakes.
module fixed2float
  import fixed2float_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic [FIX_W-1:0] fixed_in,
  input  logic             valid_in,
  output logic             ready_o,
  output logic [FP_W-1:0]  float_out,
  output logic             valid_out,
  input  logic             ready_i,
  output logic             ovf_o,
  output logic             unf_o
);

  logic advance;
  assign advance = ready_i | ~valid_out;
  assign ready_o = advance;

  s1_t              s1;
  logic             s1_valid;
  s2_t              s2;
  logic             s2_valid;
  logic [POS_W-1:0] lzd_pos;
  logic             lzd_zero;

  // Stage 1: sign, magnitude, zero flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (advance) begin
      s1_valid <= valid_in;
      s1.sign  <= fixed_in[FIX_W-1];
      s1.zero  <= ~|fixed_in;
      s1.mag   <= fix_mag(fixed_in);
    end
  end

  lzd44 u_lzd (
    .vec    (s1.mag),
    .pos_c  (lzd_pos),
    .zero_c (lzd_zero)
  );

  // Stage 2: leading-one position
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2       <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2.sign  <= s1.sign;
      s2.zero  <= s1.zero | lzd_zero;
      s2.pos   <= lzd_pos;
      s2.mag   <= s1.mag;
    end
  end

  // Stage 3 datapath: normalize so the leading one lands on the MSB, then round-to-nearest-even
  logic [FIX_W-1:0]      norm_c;
  logic                  zero_c;
  logic                  guard_c;
  logic                  sticky_c;
  logic                  round_up_c;
  logic [FP_MAN_W:0]     man_sum_c;
  logic [EXP_FULL_W-1:0] exp_full_c;
  fp16_t                 res_c;
  logic                  ovf_c;
  logic                  unf_c;

  assign norm_c     = s2.mag << (POS_W'(FIX_W - 1) - s2.pos);
  assign zero_c     = s2.zero | ~norm_c[FIX_W-1];
  assign guard_c    = norm_c[NORM_GRD];
  assign sticky_c   = |norm_c[NORM_GRD-1:0];
  assign round_up_c = guard_c & (sticky_c | norm_c[NORM_MAN_LO]);
  assign man_sum_c  = {1'b0, norm_c[NORM_MAN_HI:NORM_MAN_LO]} + (FP_MAN_W + 1)'(round_up_c);
  assign exp_full_c = EXP_FULL_W'(s2.pos) + EXP_FULL_W'(man_sum_c[FP_MAN_W])
                    - EXP_FULL_W'(EXP_OFS);

  // Classify: zero, too small, saturate, collision with the zero code, or normal
  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unf_c = 1'b0;
    if (!zero_c) begin
      if (s2.pos < POS_W'(EXP_OFS)) begin
        unf_c = 1'b1;
      end else if (exp_full_c > EXP_FULL_W'(FP_EXP_MAX)) begin
        res_c = {s2.sign, FP_SAT_MAG};
        ovf_c = 1'b1;
      end else if ((exp_full_c == '0) && (man_sum_c[FP_MAN_W-1:0] == '0)) begin
        unf_c = 1'b1;
      end else begin
        res_c.sign = s2.sign;
        res_c.exp  = exp_full_c[FP_EXP_W-1:0];
        res_c.man  = man_sum_c[FP_MAN_W-1:0];
      end
    end
  end

  // Stage 3 output register; flags are qualified so bubbles never carry them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      float_out <= '0;
      ovf_o     <= 1'b0;
      unf_o     <= 1'b0;
    end else if (advance) begin
      valid_out <= s2_valid;
      float_out <= res_c;
      ovf_o     <= s2_valid & ovf_c;
      unf_o     <= s2_valid & unf_c;
    end
  end

endmodule

// File: tb/tb_fixed2float.sv
// Self-checking bench for fixed2float: directed values, random values against an arithmetic
// reference, fp16 round trip, backpressure and mid-stream reset.
module tb_fixed2float;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [43:0] fixed_in;
  logic        valid_in;
  logic        ready_o;
  logic [15:0] float_out;
  logic        valid_out;
  logic        ready_i;
  logic        ovf_o;
  logic        unf_o;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [17:0] expq[$];
  logic [17:0] cur_exp;
  bit          rand_rdy = 1'b0;

  logic [43:0] dir_x [11] = '{
    44'h000_0200_1000, 44'h000_0200_4000, 44'h000_0200_C000, 44'h000_03FF_C000,
    44'h7FF_FFFF_FFFF, 44'h800_0000_0000, 44'h000_0000_01FF, 44'h000_0000_0400,
    44'h000_0000_0000, 44'h000_0200_0000, 44'hFFF_FE00_0000};
  logic [17:0] dir_e [11] = '{
    {16'h3C00, 2'b00}, {16'h3C00, 2'b00}, {16'h3C02, 2'b00}, {16'h4000, 2'b00},
    {16'h7FFF, 2'b10}, {16'hFFFF, 2'b10}, {16'h0000, 2'b01}, {16'h0000, 2'b01},
    {16'h0000, 2'b00}, {16'h3C00, 2'b00}, {16'hBC00, 2'b00}};

  always #5 clk = ~clk;

  fixed2float dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .fixed_in  (fixed_in),
    .valid_in  (valid_in),
    .ready_o   (ready_o),
    .float_out (float_out),
    .valid_out (valid_out),
    .ready_i   (ready_i),
    .ovf_o     (ovf_o),
    .unf_o     (unf_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: value = mag * 2^-25, rounded to 11 significant bits, ties to even
  function automatic logic [17:0] model(input logic [43:0] x);
    longint sv, mag, q, rem, half;
    int p, sh, e;
    logic s;
    sv  = longint'($signed(x));
    s   = (sv < 0);
    mag = s ? -sv : sv;
    if (mag == 0) return 18'h0;
    p = 0;
    while ((mag >> (p + 1)) != 0) p++;
    if (p < 10) return {16'h0000, 2'b01};
    sh  = p - 10;
    q   = mag >> sh;
    rem = mag - (q << sh);
    if (sh > 0) begin
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q++;
    end
    e = p - 10;
    if (q == 2048) begin
      q = 1024;
      e++;
    end
    if (e > 31) return {s, 15'h7FFF, 2'b10};
    if (e == 0 && q == 1024) return {16'h0000, 2'b01};
    return {s, 5'(e), 10'(q), 2'b00};
  endfunction

  // Forward fp16 -> Q18.25 conversion: (1.man) * 2^(exp-15) scaled by 2^25
  function automatic logic [43:0] fwd(input logic [15:0] f);
    longint m;
    m = longint'({1'b1, f[9:0]}) << f[14:10];
    if (f[15]) m = -m;
    return 44'(m);
  endfunction

  // One clock: score the handshake seen before the edge, then check hold/idle rules after it
  task automatic step(output bit acc);
    logic [17:0] snap;
    bit pop, stall;
    if (rand_rdy) ready_i = 1'($urandom_range(0, 1));
    #1;
    acc   = valid_in && ready_o;
    pop   = valid_out && ready_i;
    stall = valid_out && !ready_i;
    snap  = {float_out, ovf_o, unf_o};
    if (pop) begin
      if (expq.size() == 0) check("extra_beat", 32'(valid_out), 32'h0);
      else check("result", 32'(snap), 32'(expq.pop_front()));
    end
    if (acc) expq.push_back(cur_exp);
    @(posedge clk);
    #1;
    cyc++;
    if (stall) check("hold", 32'({valid_out, float_out, ovf_o, unf_o}), 32'({1'b1, snap}));
    if (!valid_out) check("idle_flags", 32'({ovf_o, unf_o}), 32'h0);
  endtask

  task automatic send(input logic [43:0] x, input logic [17:0] e);
    bit acc = 1'b0;
    fixed_in = x;
    valid_in = 1'b1;
    cur_exp  = e;
    for (int i = 0; i < 100; i++) begin
      step(acc);
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 32'(acc), 32'h1);
    valid_in = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    rand_rdy = 1'b0;
    ready_i  = 1'b1;
    valid_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (expq.size() == 0) break;
      step(acc);
    end
    check("drain", 32'(expq.size()), 32'h0);
  endtask

  task automatic latency_probe(input logic [43:0] x, input logic [17:0] e);
    bit acc;
    int n0;
    drain();
    fixed_in = x;
    valid_in = 1'b1;
    cur_exp  = e;
    n0 = cyc;
    step(acc);
    valid_in = 1'b0;
    check("accept", 32'(acc), 32'h1);
    for (int k = 0; k < 10; k++) begin
      if (valid_out) break;
      step(acc);
    end
    check("latency", 32'(cyc - n0), 32'h3);
    drain();
  endtask

  initial begin
    bit acc;
    logic [43:0] r;
    reset_n  = 1'b0;
    fixed_in = '0;
    valid_in = 1'b0;
    ready_i  = 1'b1;
    cur_exp  = '0;
    #12;
    check("reset_state", 32'({valid_out, float_out, ovf_o, unf_o}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    latency_probe(44'h000_0200_0000, {16'h3C00, 2'b00});
    latency_probe(44'hFFF_FE00_0000, {16'hBC00, 2'b00});

    for (int i = 0; i < 11; i++) send(dir_x[i], dir_e[i]);
    drain();

    for (int i = 0; i < 400; i++) begin
      r = 44'({$urandom(), $urandom()}) >> $urandom_range(0, 43);
      if ($urandom_range(0, 1) == 1) r = -r;
      send(r, model(r));
    end
    drain();

    // Round trip through the forward conversion: all positive words, a stride of negatives
    for (int f = 1; f < 32768; f++) send(fwd(16'(f)), {16'(f), 2'b00});
    for (int f = 32769; f < 65536; f += 7) send(fwd(16'(f)), {16'(f), 2'b00});
    drain();

    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      r = 44'({$urandom(), $urandom()}) >> $urandom_range(0, 43);
      if ($urandom_range(0, 1) == 1) r = -r;
      send(r, model(r));
      if ($urandom_range(0, 2) == 0) step(acc);
    end
    drain();

    // Mid-stream reset with three beats in flight
    send(44'h000_0200_0000, {16'h3C00, 2'b00});
    send(44'h000_0400_0000, {16'h4000, 2'b00});
    send(44'h000_0100_0000, {16'h3800, 2'b00});
    #2;
    reset_n = 1'b0;
    #1;
    check("reset_midop", 32'({valid_out, float_out, ovf_o, unf_o}), 32'h0);
    #2;
    reset_n = 1'b1;
    expq.delete();
    for (int i = 0; i < 6; i++) begin
      step(acc);
      check("no_stale", 32'(valid_out), 32'h0);
    end
    latency_probe(44'hFFF_FC00_0000, {16'hC000, 2'b00});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed2float.md
# fixed2float

Converts 44-bit signed fixed-point accumulator values back to IEEE-style half-precision (fp16) words. It is the inverse of the existing fp16-to-fixed converter: for every nonzero fp16 input, the fixed result it produces maps back to the identical fp16 word. It sits at the output of the neuron accumulation datapath, ahead of result write-back. It is a 3-stage pipeline with valid/ready flow control.

## Interface
- FIX_W, 44: fixed input width. Fixed for this design; not to be overridden.
- FRAC_W, 25: fraction bits of the fixed format (Q18.25 two's complement, LSB = 2^-25).
- clk  input  1  clock; all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- fixed_in  input  44  two's-complement value, Q18.25
- valid_in  input  1  fixed_in is valid this cycle
- ready_o  output  1  block accepts input this cycle
- float_out  output  16  fp16 result {sign, exp[4:0], man[9:0]}, bias 15
- valid_out  output  1  float_out is valid
- ready_i  input  1  downstream accepts float_out
- ovf_o  output  1  result saturated; qualified by valid_out
- unf_o  output  1  nonzero input flushed to zero; qualified by valid_out

## Operation
- Encoding is the same as the forward converter: value = 1.man × 2^(exp−15) for every exp, including 0 and 31. There are no denormals, infinities or NaNs. 16'h0000 is zero.
- Stage 1 captures the sign and computes the 44-bit unsigned magnitude. −2^43 gives magnitude 2^43. It also flags zero.
- Stage 2 finds the leading-one position p (0..43) of the magnitude.
- Stage 3 normalizes, rounds and packs the result:
  - exp = p − 10.
  - man = magnitude bits [p−1:p−10]. Guard bit = p−11; sticky = OR of bits below the guard.
  - Rounding is round-to-nearest, ties-to-even. A mantissa carry-out increments exp and clears man.
- Saturation: if exp > 31 after rounding (p ≥ 42, or a carry at p = 41), output {sign, 15'h7FFF} and set ovf_o.
- Flush: if p < 10, or the rounded result is exp 0 / man 0 (which collides with the zero encoding), output 16'h0000 and set unf_o.
- A zero input gives 16'h0000 with no flags. Output zero is always +0.
- The sign is forced to 0 whenever the output is 16'h0000.

## Timing
- Latency: a beat accepted on cycle N appears on valid_out at cycle N+3 when there is no stall. Throughput is 1 per cycle.
- Global stall: advance = ready_i | ~valid_out. All three stages load only when advance is high.
- ready_o = advance. This is a combinational path from ready_i.
- valid_in with ready_o low: the input is not taken, and the source must hold it.
- While valid_out & ~ready_i: float_out, ovf_o, unf_o and valid_out hold stable. No beat is lost or duplicated.
- Bubbles (valid low) propagate as ordinary beats. Data registers in bubble stages are don't-care, but flags must be 0 whenever valid_out is 0.
- Reset: asserting reset_n low at any time, including mid-stream, clears every stage valid immediately. Outputs reset to float_out = 0, valid_out = 0, ovf_o = 0, unf_o = 0. In-flight beats are discarded.

## Structure
- Constants for the shared package/header: FIX_W = 44, FRAC_W = 25, FP_EXP_W = 5, FP_MAN_W = 10, FP_BIAS = 15, FP_SAT_MAG = 15'h7FFF. The forward converter uses the same constants.
- One sub-module, `lzd44`: a purely combinational 44-bit leading-one detector. It outputs a 6-bit position and a zero flag, and is instantiated in stage 2.
- Pipeline registers and the stall logic live in the top module.

## Test plan
- Basic values: fixed_in 44'h000_0200_0000 gives 16'h3C00, and 44'hFFF_FE00_0000 gives 16'hBC00; both with no flags, and valid_out 3 cycles after acceptance.
- Rounding:
  - 44'h000_0200_1000 gives 16'h3C00 (below half).
  - 44'h000_0200_4000 gives 16'h3C00 (tie, even).
  - 44'h000_0200_C000 gives 16'h3C02 (tie, odd, rounds up).
  - 44'h000_03FF_C000 gives 16'h4000 (carry increments exp).
- Boundaries:
  - 44'h7FF_FFFF_FFFF gives 16'h7FFF with ovf_o.
  - 44'h800_0000_0000 gives 16'hFFFF with ovf_o.
  - 44'h000_0000_01FF gives 16'h0000 with unf_o.
  - 44'h000_0000_0400 gives 16'h0000 with unf_o.
  - 0 gives 16'h0000 with no flags.
- Round trip: sweep all fp16 words with nonzero bits [14:0] through the forward converter and then this block. The output must equal the input exactly.
- Backpressure: stream 10 beats with ready_i toggling pseudo-randomly. The output sequence must be exactly the 10 expected values in order, and float_out must stay stable on every valid_out & ~ready_i cycle.
- Reset mid-operation: with 3 beats in flight, pulse reset_n low between clock edges. valid_out must drop immediately, no stale beat may appear after release, and the next accepted beat must arrive at N+3.
